pend_sched: RTL

- Periodic and external-event scheduler that feeds pend requests into the n_clic vector table.
- Each channel owns a programmable period counter and one external request line.
- Expiries and rising edges become pend requests. A round-robin arbiter serialises them onto a single valid/ready port that the clic consumes, at most one entry pend per handshake.
- Configured through CSRs on the shared CSR bus, alongside the timer and m_int_thresh.

---
 rtl/pend_sched.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/pend_sched.sv
// Periodic / external-event scheduler: per-channel period counters and edge detectors
// raise requests that a round-robin arbiter presents one at a time on a valid/ready pend port.

package pend_sched_pkg;
  typedef enum logic [2:0] {
    CSR_RSV0 = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_RSV1 = 3'b100,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_op_t;
endpackage

module pend_sched_chan #(
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CntWidth-1:0] wr_data,
  input  logic                ext_irq,
  output logic                evt,
  output logic [CntWidth-1:0] period
);
  logic [CntWidth-1:0] cnt;
  logic                ext_prev;
  logic                per_evt;

  // period - 1 is only looked at when the channel is enabled
  always_comb begin
    per_evt = 1'b0;
    if (period != '0) per_evt = (cnt == period - CntWidth'(1));
    evt = per_evt | (ext_irq & ~ext_prev);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period   <= '0;
      cnt      <= '0;
      ext_prev <= 1'b0;
    end else begin
      ext_prev <= ext_irq;
      if (wr_en) begin
        period <= wr_data;
        cnt    <= '0;
      end else if (period == '0 || per_evt) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CntWidth'(1);
      end
    end
  end
endmodule

module pend_sched
  import pend_sched_pkg::*;
#(
  parameter int          Channels      = 4,
  parameter int          VecBase       = 1,
  parameter int          VecSize       = 32,
  parameter int          CntWidth      = 16,
  parameter logic [11:0] PeriodCsrBase = 12'h3C0,
  parameter logic [11:0] StatusAddr    = 12'h3BF,
  localparam int         VecW          = $clog2(VecSize),
  localparam int         ChW           = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                csr_enable,
  input  logic [11:0]         csr_addr,
  input  csr_op_t             csr_op,
  input  logic [4:0]          rs1_zimm,
  input  logic [31:0]         rs1_data,
  input  logic [Channels-1:0] ext_irq,
  input  logic                pend_ready,
  output logic                pend_valid,
  output logic [VecW-1:0]     pend_index,
  output logic [31:0]         csr_out
);
  typedef enum logic {ST_IDLE, ST_OFFER} st_t;

  logic [Channels-1:0][CntWidth-1:0] period;
  logic [Channels-1:0] evt, req, ovr, req_d, ovr_d, ovr_set, ovr_clr, grant;
  logic [Channels-1:0] period_hit, period_wr;
  logic                status_hit, status_wr, wr_go;
  logic [31:0]         operand, old_val, wval;
  logic                unused_wval;

  st_t                 st_q, st_d;
  logic [ChW-1:0]      sel_q, sel_nxt, rr_ptr, idx;
  logic                found;

  // ---------------- CSR decode / read / write value
  assign status_hit = (csr_addr == StatusAddr);

  always_comb begin
    operand = (csr_op inside {CSR_RWI, CSR_RSI, CSR_RCI}) ? {27'b0, rs1_zimm} : rs1_data;
    old_val = '0;
    if (status_hit) old_val = 32'({ovr, req});
    for (int c = 0; c < Channels; c++)
      if (period_hit[c]) old_val = 32'(period[c]);
    csr_out = old_val;

    wval  = operand;
    wr_go = 1'b0;
    // set/clear with a zero operand is a pure read
    if (csr_op inside {CSR_RW, CSR_RWI}) begin
      wval  = operand;
      wr_go = csr_enable;
    end else if (csr_op inside {CSR_RS, CSR_RSI}) begin
      wval  = old_val | operand;
      wr_go = csr_enable && (operand != '0);
    end else if (csr_op inside {CSR_RC, CSR_RCI}) begin
      wval  = old_val & ~operand;
      wr_go = csr_enable && (operand != '0);
    end
  end

  assign status_wr   = wr_go & status_hit;
  assign unused_wval = ^wval;

  // ---------------- per-channel counters and edge detect
  for (genvar c = 0; c < Channels; c++) begin : g_chan
    assign period_hit[c] = (csr_addr == PeriodCsrBase + 12'(c));
    assign period_wr[c]  = wr_go & period_hit[c];

    pend_sched_chan #(.CntWidth(CntWidth)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (period_wr[c]),
      .wr_data (wval[CntWidth-1:0]),
      .ext_irq (ext_irq[c]),
      .evt     (evt[c]),
      .period  (period[c])
    );
  end

  // ---------------- request / overrun bookkeeping
  // a channel granted this cycle may re-request without counting as an overrun
  always_comb begin
    ovr_clr = status_wr ? wval[2*Channels-1:Channels] : '0;
    ovr_set = evt & req & ~grant;
    req_d   = (req & ~grant) | evt;
    ovr_d   = (ovr & ~ovr_clr) | ovr_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req <= '0;
      ovr <= '0;
    end else begin
      req <= req_d;
      ovr <= ovr_d;
    end
  end

  // ---------------- round-robin arbiter
  always_comb begin
    sel_nxt = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < Channels; i++) begin
      idx = ChW'((int'(rr_ptr) + i) % Channels);
      if (!found && req[idx]) begin
        found   = 1'b1;
        sel_nxt = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      sel_q      <= '0;
      rr_ptr     <= '0;
      pend_index <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == ST_IDLE && found) begin
        sel_q      <= sel_nxt;
        pend_index <= VecW'(VecBase + int'(sel_nxt));
      end
      if (st_q == ST_OFFER && pend_ready)
        rr_ptr <= ChW'((int'(sel_q) + 1) % Channels);
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  if (found)      st_d = ST_OFFER;
      ST_OFFER: if (pend_ready) st_d = ST_IDLE;
      default:                  st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_valid = (st_q == ST_OFFER);
    grant      = '0;
    if (st_q == ST_OFFER && pend_ready) grant[sel_q] = 1'b1;
  end
endmodule
